// File: rtl/core.sv
// Single-cycle RV32I subset core: one externally supplied instruction is decoded,
// executed and retired per accepted clock edge. Holds a 32x32 register file and 1K-word data memory.

module regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data
);
  logic [31:0] registers [32];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 32; i++) registers[i] <= '0;
    end else if (we && rd_addr != 5'd0) begin
      registers[rd_addr] <= rd_data;
    end
  end

  assign rs1_data = (rs1_addr == 5'd0) ? '0 : registers[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? '0 : registers[rs2_addr];
endmodule

module data_mem (
  input  logic        clk,
  input  logic        we,
  input  logic [9:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  // Deliberately not reset: contents survive a core reset.
  logic [31:0] mem_data [1024];

  always_ff @(posedge clk) begin
    if (we) mem_data[addr] <= wdata;
  end

  assign rdata = mem_data[addr];
endmodule

module core (
  input logic        clk,
  input logic        reset,
  input logic        i_req_instr,
  input logic [31:0] i_instr
);
  typedef enum logic [6:0] {
    OP_R     = 7'b0110011,
    OP_IMM   = 7'b0010011,
    OP_LOAD  = 7'b0000011,
    OP_STORE = 7'b0100011,
    OP_LUI   = 7'b0110111
  } opcode_t;

  logic [31:0] pc, instr;
  logic [4:0]  rd_addr, rs1_addr, rs2_addr;
  logic [31:0] rd_data, rs1_data, rs2_data;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, mem_addr, mem_rdata;
  logic        rd_we, mem_we;

  assign rd_addr  = i_instr[11:7];
  assign rs1_addr = i_instr[19:15];
  assign rs2_addr = i_instr[24:20];
  assign funct3   = i_instr[14:12];
  assign funct7   = i_instr[31:25];
  assign imm_i    = {{20{i_instr[31]}}, i_instr[31:20]};
  assign imm_s    = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign mem_addr = rs1_data + ((i_instr[6:0] == OP_STORE) ? imm_s : imm_i);

  function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  alu = alt ? a - b : a + b;
      3'b001:  alu = a << b[4:0];
      3'b010:  alu = {31'b0, $signed(a) < $signed(b)};
      3'b011:  alu = {31'b0, a < b};
      3'b100:  alu = a ^ b;
      3'b101:  alu = alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'b110:  alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  always_comb begin
    rd_data = '0;
    rd_we   = 1'b0;
    mem_we  = 1'b0;
    case (i_instr[6:0])
      OP_R: begin
        rd_data = alu(funct3, funct7[5], rs1_data, rs2_data);
        rd_we   = 1'b1;
      end
      OP_IMM: begin
        // ADDI has no subtract form; only the right-shift uses funct7 as a selector.
        rd_data = alu(funct3, (funct3 == 3'b101) && funct7[5], rs1_data, imm_i);
        rd_we   = 1'b1;
      end
      OP_LOAD: begin
        if (funct3 == 3'b010) begin
          rd_data = mem_rdata;
          rd_we   = 1'b1;
        end
      end
      OP_STORE: mem_we = (funct3 == 3'b010);
      OP_LUI: begin
        rd_data = {i_instr[31:12], 12'b0};
        rd_we   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc    <= '0;
      instr <= '0;
    end else if (i_req_instr) begin
      pc    <= pc + 32'd4;
      instr <= i_instr;
    end
  end

  regfile rf (
    .clk      (clk),
    .reset    (reset),
    .we       (i_req_instr && rd_we),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data)
  );

  // Memory has no reset of its own, so a write is also blocked while reset is held.
  data_mem mem (
    .clk   (clk),
    .we    (i_req_instr && mem_we && reset),
    .addr  (mem_addr[11:2]),
    .wdata (rs2_data),
    .rdata (mem_rdata)
  );
endmodule

// File: tb/tb_core.sv
// Self-checking bench for core: expected architectural state is queued as each
// instruction is driven and compared against the internal arrays after the edge.

module tb_core;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_req_instr = 1'b0;
  logic [31:0] i_instr = '0;

  core dut (
    .clk         (clk),
    .reset       (reset),
    .i_req_instr (i_req_instr),
    .i_instr     (i_instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 reg, 1 mem, 2 pc, 3 instr
    int          idx;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_pc = '0;

  function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3,
                                      input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd,
                                      input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] s_t(input logic [11:0] imm, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] actual(input int kind, input int idx);
    case (kind)
      0:       return dut.rf.registers[idx];
      1:       return dut.mem.mem_data[idx];
      2:       return dut.pc;
      default: return dut.instr;
    endcase
  endfunction

  task automatic exp_reg(input int r, input logic [31:0] v, input string n);
    sb.push_back('{0, r, v, n});
  endtask

  task automatic exp_mem(input int w, input logic [31:0] v, input string n);
    sb.push_back('{1, w, v, n});
  endtask

  task automatic collect();
    while (sb.size() > 0) begin
      exp_t        e;
      logic [31:0] a;
      e = sb.pop_front();
      a = actual(e.kind, e.idx);
      total++;
      if (a !== e.val) begin
        bad++;
        $display("FAIL %s: got %h expected %h", e.name, a, e.val);
      end
    end
  endtask

  task automatic exec(input logic [31:0] ins, input string n);
    exp_pc += 32'd4;
    sb.push_back('{2, 0, exp_pc, {n, ".pc"}});
    sb.push_back('{3, 0, ins, {n, ".instr"}});
    @(negedge clk);
    i_instr     = ins;
    i_req_instr = 1'b1;
    @(posedge clk);
    #1;
    collect();
  endtask

  task automatic idle(input string n);
    sb.push_back('{2, 0, exp_pc, {n, ".pc"}});
    @(negedge clk);
    i_req_instr = 1'b0;
    i_instr     = i_t(12'h123, 5'd0, 3'b000, 5'd1, 7'h13);
    @(posedge clk);
    #1;
    collect();
  endtask

  task automatic test_reset();
    int nz;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (dut.pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h expected 0", dut.pc); end
    total++;
    if (dut.instr !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h expected 0", dut.instr); end
    nz = 0;
    for (int i = 0; i < 32; i++) if (dut.rf.registers[i] !== 32'h0) nz++;
    total++;
    if (nz != 0) begin bad++; $display("FAIL reset_regs: nonzero=%0d expected 0", nz); end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) idle("idle_after_reset");
    for (int i = 0; i < 32; i += 8) exp_reg(i, 32'h0, "regs_after_idle");
    sb.push_back('{3, 0, 32'h0, "instr_after_idle"});
    collect();
  endtask

  task automatic test_alu();
    exp_reg(2, 32'd7, "addi_x2");        exec(i_t(12'd7, 5'd0, 3'b000, 5'd2, 7'h13), "addi_x2");
    exp_reg(3, 32'd5, "addi_x3");        exec(i_t(12'd5, 5'd0, 3'b000, 5'd3, 7'h13), "addi_x3");
    exp_reg(1, 32'h0000000C, "add");     exec(32'h003100B3, "add");
    exp_reg(1, 32'd2, "sub");            exec(32'h403100B3, "sub");
    exp_reg(6, 32'hFFFFFFFE, "sub_neg"); exec(32'h40218333, "sub_neg");
    exp_reg(7, 32'hFFFFFFFF, "sra");     exec(r_t(7'h20, 5'd2, 5'd6, 3'b101, 5'd7), "sra");
    exp_reg(8, 32'h01FFFFFF, "srl");     exec(r_t(7'h00, 5'd2, 5'd6, 3'b101, 5'd8), "srl");
    exp_reg(9, 32'd1, "slt");            exec(r_t(7'h00, 5'd2, 5'd6, 3'b010, 5'd9), "slt");
    exp_reg(10, 32'd0, "sltu");          exec(r_t(7'h00, 5'd2, 5'd6, 3'b011, 5'd10), "sltu");
    exp_reg(11, 32'd2, "xor");           exec(r_t(7'h00, 5'd3, 5'd2, 3'b100, 5'd11), "xor");
    exp_reg(12, 32'd7, "or");            exec(r_t(7'h00, 5'd3, 5'd2, 3'b110, 5'd12), "or");
    exp_reg(13, 32'd5, "and");           exec(r_t(7'h00, 5'd3, 5'd2, 3'b111, 5'd13), "and");
    exp_reg(14, 32'h280, "sll");         exec(r_t(7'h00, 5'd2, 5'd3, 3'b001, 5'd14), "sll");
    exp_reg(15, 32'h80000000, "slli");   exec(i_t(12'h01F, 5'd3, 3'b001, 5'd15, 7'h13), "slli");
    exp_reg(16, 32'hF8000000, "srai");   exec(i_t(12'h404, 5'd15, 3'b101, 5'd16, 7'h13), "srai");
    exp_reg(17, 32'd1, "slti");          exec(i_t(12'hFFF, 5'd6, 3'b010, 5'd17, 7'h13), "slti");
    exp_reg(18, 32'd1, "sltiu");         exec(i_t(12'hFFF, 5'd2, 3'b011, 5'd18, 7'h13), "sltiu");
    exp_reg(19, 32'hFFFFFFF8, "xori");   exec(i_t(12'hFFF, 5'd2, 3'b100, 5'd19, 7'h13), "xori");
    exp_reg(20, 32'h000000F0, "andi");   exec(i_t(12'h0F0, 5'd6, 3'b111, 5'd20, 7'h13), "andi");
    exp_reg(21, 32'h00000555, "ori");    exec(i_t(12'h555, 5'd0, 3'b110, 5'd21, 7'h13), "ori");
    exp_reg(22, 32'hFFFFFFFF, "addi_neg"); exec(i_t(12'hFF8, 5'd2, 3'b000, 5'd22, 7'h13), "addi_neg");
    exp_reg(23, 32'h12345000, "lui");    exec({20'h12345, 5'd23, 7'h37}, "lui");
    exp_reg(24, 32'h0, "add_wrap");      exec(r_t(7'h00, 5'd15, 5'd15, 3'b000, 5'd24), "add_wrap");
    exp_reg(25, 32'd1, "srl_shamt31");   exec(r_t(7'h00, 5'd22, 5'd6, 3'b101, 5'd25), "srl_shamt31");
    idle("alu_end");
  endtask

  task automatic test_memory();
    exp_reg(4, 32'd16, "addi_x4");       exec(32'h01000213, "addi_x4");
    exp_mem(4, 32'd2, "sw_word4");       exec(32'h00122023, "sw_word4");
    exp_reg(5, 32'd2, "lw_x5");          exec(32'h00022283, "lw_x5");
    exp_reg(27, 32'h1000, "lui_4k");     exec({20'h00001, 5'd27, 7'h37}, "lui_4k");
    exp_reg(27, 32'h1010, "addr_alias"); exec(r_t(7'h00, 5'd4, 5'd27, 3'b000, 5'd27), "addr_alias");
    exp_mem(4, 32'd5, "sw_alias");       exec(s_t(12'd0, 5'd3, 5'd27, 3'b010), "sw_alias");
    exp_reg(28, 32'd5, "lw_low_bits");   exec(i_t(12'd3, 5'd4, 3'b010, 5'd28, 7'h03), "lw_low_bits");
    exp_mem(3, 32'd7, "sw_neg_off");     exec(s_t(12'hFFC, 5'd2, 5'd4, 3'b010), "sw_neg_off");
    exp_reg(29, 32'd7, "lw_neg_off");    exec(i_t(12'hFFC, 5'd4, 3'b010, 5'd29, 7'h03), "lw_neg_off");
    exp_mem(4, 32'd2, "sw_restore");     exec(32'h00122023, "sw_restore");
    idle("mem_end");
  endtask

  task automatic test_x0_nop();
    exp_reg(0, 32'h0, "x0_write");       exec(i_t(12'd5, 5'd0, 3'b000, 5'd0, 7'h13), "x0_write");
    exp_reg(30, 32'd7, "x0_read");       exec(r_t(7'h00, 5'd2, 5'd0, 3'b000, 5'd30), "x0_read");
    exp_reg(31, 32'h0, "nop_7f_reg");
    exp_mem(4, 32'd2, "nop_7f_mem");     exec(32'hFFFFFFFF, "nop_7f");
    exp_reg(5, 32'd2, "lb_is_nop");      exec(i_t(12'd0, 5'd4, 3'b000, 5'd5, 7'h03), "lb_is_nop");
    exp_mem(4, 32'd2, "sb_is_nop");      exec(s_t(12'd0, 5'd3, 5'd4, 3'b000), "sb_is_nop");
    idle("nop_end");
  endtask

  task automatic test_idle_gaps();
    for (int i = 1; i <= 4; i++) begin
      exp_reg(26, 32'(i), "gap_incr");
      exec(i_t(12'd1, 5'd26, 3'b000, 5'd26, 7'h13), "gap_exec");
      exp_reg(26, 32'(i), "gap_hold");
      idle("gap_idle");
    end
  endtask

  task automatic test_reset_mid();
    int nz;
    @(negedge clk);
    i_instr     = s_t(12'd16, 5'd0, 5'd0, 3'b010);
    i_req_instr = 1'b1;
    #2 reset = 1'b0;
    #1;
    nz = 0;
    for (int i = 1; i < 32; i++) if (dut.rf.registers[i] !== 32'h0) nz++;
    total++;
    if (dut.pc !== 32'h0) begin bad++; $display("FAIL midreset_pc: got %h expected 0", dut.pc); end
    total++;
    if (nz != 0) begin bad++; $display("FAIL midreset_regs: nonzero=%0d expected 0", nz); end
    @(posedge clk);
    #1;
    exp_pc = '0;
    exp_mem(4, 32'd2, "midreset_mem4");
    sb.push_back('{2, 0, 32'h0, "midreset_pc_held"});
    sb.push_back('{3, 0, 32'h0, "midreset_instr_held"});
    collect();
    exp_pc = 32'd4;
    exp_reg(1, 32'd3, "first_after_reset");
    sb.push_back('{2, 0, exp_pc, "first_after_reset.pc"});
    @(negedge clk);
    reset       = 1'b1;
    i_instr     = i_t(12'd3, 5'd0, 3'b000, 5'd1, 7'h13);
    i_req_instr = 1'b1;
    @(posedge clk);
    #1;
    collect();
    idle("after_reset_end");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_alu();
    test_memory();
    test_x0_nop();
    test_idle_gaps();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
